dmem_lsu: RTL
=============

# dmem_lsu

Parametrised successor to the single-cycle data memory: a byte-addressable, word-organised RAM with RV32 load/store sizing (LB/LH/LW/LBU/LHU, SB/SH/SW), a valid/ready request port and a registered response. Misaligned accesses are either split into two word beats by an internal FSM or rejected with an error flag, selected by parameter. It sits between the CPU's memory stage and data storage. Its 1-cycle read latency and back-pressure let the pipelined core replace the combinational-read memory.

## Interface
- DATA_WIDTH, 32, word width; fixed at 32 (RV32), checked at elaboration
- ADDR_WIDTH, 32, byte-address width
- MEM_SIZE, 64, depth in words; power of two ≥ 2
- SPLIT_MISALIGNED, 1, 1 = split misaligned access into two beats; 0 = reject with rsp_err
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data, low bytes used for B/H
- rsp_valid  output  1  one-cycle pulse per accepted request; no back-pressure
- rsp_rdata  output  DATA_WIDTH  load result, sign/zero-extended; 0 for stores and errors
- rsp_err  output  1  valid with rsp_valid: illegal funct3, or misaligned with SPLIT_MISALIGNED=0

## Operation
- Word index is addr[ADDR_WIDTH-1:2] mod MEM_SIZE. Indices wrap, so index MEM_SIZE-1 + 1 = 0.
- Byte offset is addr[1:0]. Access size is 1, 2 or 4 bytes.
- An access is misaligned when offset + size > 4. H at offset 3 and W at offsets 1–3 are misaligned.
- Stores write only the addressed byte lanes via per-byte write enables. Other bytes are preserved.
- Loads extract the addressed bytes and right-justify them. B/H are sign-extended; BU/HU are zero-extended.
- Illegal funct3 (011, 110, 111, or any sign-less store code 100/101) gives rsp_err=1 with no memory access.
- Memory contents are not reset.
- FSM states are IDLE and BEAT2:
  - IDLE → BEAT2 on acceptance of a misaligned legal access when SPLIT_MISALIGNED=1. Beat 1 covers word w, lanes offset..3.
  - BEAT2 → IDLE unconditionally. Beat 2 covers word (w+1) mod MEM_SIZE, lanes 0..(offset+size-5).
- Latched request fields (we, funct3, offset, wdata, w) are held for beat 2.
- A split load registers its beat-1 bytes, then merges them with the beat-2 bytes, then extends the result.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- Aligned access, or rejected access, accepted in cycle N:
  - Array write or read occurs at the edge ending cycle N.
  - rsp_valid=1 in cycle N+1.
- Split access accepted in cycle N:
  - Beat 1 occurs at the edge ending N.
  - req_ready=0 during cycle N+1, when beat 2 occurs.
  - rsp_valid=1 in cycle N+2.
- Back-to-back aligned requests are accepted every cycle. A new request may be accepted in the same cycle rsp_valid is high.
- Read-after-write to the same word in consecutive cycles returns the newly written data.
- Reset asserted mid-split: FSM returns to IDLE and no response is issued. Beat 1 of a store may already be committed; this is permitted.

## Structure
- Shared package `dmem_pkg` holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum {IDLE, BEAT2}
  - a size-from-funct3 function
- One sub-module, `dmem_bank`: MEM_SIZE × 4-byte array with 4 byte write enables and a registered read, one port.
- Top-level `dmem_lsu` holds the FSM, lane/enable generation, merge and extension logic.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata=0xDEADBEEF in cycle N+1, rsp_err=0; back-to-back accepts with req_ready held at 1.
- Preload 0x11223344 @0x20. SB 0xAA @0x21, then LW @0x20 → 0x1122AA44. LB @0x21 → 0xFFFFFFAA. LBU @0x21 → 0x000000AA. LH @0x22 → 0x00001122.
- SPLIT=1: words @0x30=0x44332211, @0x34=0x88776655. LW @0x33 → 0x77665544 at N+2, with req_ready=0 at N+1. SH 0xBEEF @0x37 → LW @0x34=0xEF776655, LW @0x38 low byte 0xBE.
- SPLIT=1, MEM_SIZE=64: SW 0xCAFEF00D @0xFE → word 63 bytes[3:2]=0xF00D, word 0 bytes[1:0]=0xCAFE (wrap).
- SPLIT=0: LW @0x01 → rsp_err=1, rsp_rdata=0, no array change. funct3=011 store → rsp_err=1, memory unchanged.
- Assert reset during BEAT2 of a split load → rsp_valid stays 0, req_ready=1 and state IDLE immediately after reset. The next aligned LW completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the load/store data memory: funct3 codes, FSM states
// and size/legality helpers.
package dmem_pkg;

    localparam int unsigned LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        BEAT2
    } state_t;

    // Access size in bytes; 0 for codes with no defined size
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            F3_W:        return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

    // Stores have no unsigned variants
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [LANES-1:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd4:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word array with per-byte write enables and a registered read.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 64,
    parameter int unsigned IDX_W    = 6
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [LANES-1:0] be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_SIZE];

    // Contents are deliberately not reset; the read register only moves on loads
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 load/store unit in front of a word-organised data RAM; misaligned accesses
// are either split into two word beats or rejected, chosen by SPLIT_MISALIGNED.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned MEM_SIZE         = 64,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("dmem_lsu: DATA_WIDTH must be 32");
    end
    if ((MEM_SIZE < 2) || ((MEM_SIZE & (MEM_SIZE - 1)) != 0)) begin : g_bad_depth
        $error("dmem_lsu: MEM_SIZE must be a power of two >= 2");
    end

    state_t state_q, state_d;

    logic             we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [31:0]      wdata_q;
    logic [IDX_W-1:0] widx_q;
    logic [31:0]      lo_q;
    logic             rsp_valid_q, rsp_err_q, rsp_load_q, rsp_split_q;
    logic             rsp_valid_d, rsp_err_d, rsp_load_d, rsp_split_d;
    logic             latch;

    logic             bank_en, bank_we;
    logic [LANES-1:0] bank_be;
    logic [IDX_W-1:0] bank_idx;
    logic [31:0]      bank_wdata, bank_rdata;

    logic [IDX_W-1:0] req_idx;
    logic [1:0]       req_off;
    logic [2:0]       req_size;
    logic             req_legal, req_mis;
    logic             unused_addr_bits;

    assign req_idx          = req_addr[2 +: IDX_W];
    assign req_off          = req_addr[1:0];
    assign req_size         = f3_size(req_funct3);
    assign req_legal        = f3_legal(req_we, req_funct3);
    assign req_mis          = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;
    assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:2+IDX_W];

    // Lane enables and store data laid out over a two-word window starting at word w
    logic [2:0]  cur_f3;
    logic [1:0]  cur_off;
    logic [31:0] cur_wdata;
    logic [7:0]  mask8;
    logic [63:0] wide_wdata;

    assign cur_f3     = (state_q == BEAT2) ? f3_q    : req_funct3;
    assign cur_off    = (state_q == BEAT2) ? off_q   : req_off;
    assign cur_wdata  = (state_q == BEAT2) ? wdata_q : 32'(req_wdata);
    assign mask8      = {4'b0000, size_mask(f3_size(cur_f3))} << cur_off;
    assign wide_wdata = {32'h0, cur_wdata} << {cur_off, 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        latch       = 1'b0;
        bank_en     = 1'b0;
        bank_we     = 1'b0;
        bank_be     = '0;
        bank_idx    = req_idx;
        bank_wdata  = wide_wdata[31:0];
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_load_d  = 1'b0;
        rsp_split_d = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    latch = 1'b1;
                    if (!req_legal || (req_mis && !SPLIT_MISALIGNED)) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        bank_en = 1'b1;
                        bank_we = req_we;
                        bank_be = mask8[3:0];
                        if (req_mis) begin
                            state_d = BEAT2;
                        end else begin
                            rsp_valid_d = 1'b1;
                            rsp_load_d  = !req_we;
                        end
                    end
                end
            end
            BEAT2: begin
                bank_en     = 1'b1;
                bank_we     = we_q;
                bank_be     = mask8[7:4];
                bank_idx    = widx_q + IDX_W'(1);
                bank_wdata  = wide_wdata[63:32];
                rsp_valid_d = 1'b1;
                rsp_load_d  = !we_q;
                rsp_split_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields held for beat 2 and for shaping the response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0;
            widx_q      <= '0;
            lo_q        <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_split_q <= 1'b0;
        end else begin
            if (latch) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                off_q   <= req_off;
                wdata_q <= 32'(req_wdata);
                widx_q  <= req_idx;
            end
            if (state_q == BEAT2) lo_q <= bank_rdata;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
            rsp_split_q <= rsp_split_d;
        end
    end

    dmem_bank #(
        .MEM_SIZE(MEM_SIZE),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk  (clk),
        .en   (bank_en),
        .we   (bank_we),
        .be   (bank_be),
        .idx  (bank_idx),
        .wdata(bank_wdata),
        .rdata(bank_rdata)
    );

    // Merge the held beat-1 word below the fresh read, shift down by the offset, extend
    logic [31:0] lo_word, hi_word, shifted, extended;

    always_comb begin
        lo_word = rsp_split_q ? lo_q : bank_rdata;
        hi_word = rsp_split_q ? bank_rdata : 32'h0;
        shifted = 32'({hi_word, lo_word} >> {off_q, 3'b000});
        case (f3_q)
            F3_B:    extended = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    extended = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   extended = {24'h0, shifted[7:0]};
            F3_HU:   extended = {16'h0, shifted[15:0]};
            default: extended = shifted;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_load_q ? DATA_WIDTH'(extended) : '0;

endmodule
